// File: rtl/ee457_alu_muldiv_if.sv
// EX-stage ALU handshake bundle: launch side (start/func/operands)
// and result side (busy/done/res/hi/lo/flags).
interface ee457_alu_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [5:0]       func;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             zero;
    logic             cout;
    logic             uov;
    logic             sov;
    logic             dz;

    modport master (
        output start, func, opa, opb,
        input  busy, done, res, hi, lo,
        input  zero, cout, uov, sov, dz
    );

    modport slave (
        input  start, func, opa, opb,
        output busy, done, res, hi, lo,
        output zero, cout, uov, sov, dz
    );
endinterface

// File: rtl/ee457_alu_muldiv.sv
// Registered EX-stage ALU with iterative MULT/DIV and HI/LO.
// Single-cycle ops complete at the launch edge; muldiv runs CALC/FIX/DONE.
module ee457_alu_muldiv #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input logic               clk,
    input logic               rst_n,
    ee457_alu_muldiv_if.slave bus
);
    localparam logic [5:0] F_SLL   = 6'h00;
    localparam logic [5:0] F_SRL   = 6'h02;
    localparam logic [5:0] F_SRA   = 6'h03;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_XOR   = 6'h26;
    localparam logic [5:0] F_NOR   = 6'h27;
    localparam logic [5:0] F_SLT   = 6'h2A;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t           state;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             zero_q;
    logic             cout_q;
    logic             uov_q;
    logic             sov_q;
    logic             dz_q;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] dvs;
    logic [SHW-1:0]   cnt;
    logic             is_div;
    logic             neg_p;
    logic             neg_r;
    logic             dz_pend;

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] bb;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             is_sub;
    logic             sov_c;
    logic [SHW-1:0]   shamt;

    assign a      = bus.opa;
    assign b      = bus.opb;
    assign shamt  = a[SHW-1:0];
    assign is_sub = (bus.func == F_SUB) || (bus.func == F_SLT);
    assign bb     = is_sub ? ~b : b;
    assign {carry, sum} = {1'b0, a} + {1'b0, bb}
                        + (WIDTH+1)'(is_sub);
    assign sov_c  = (a[WIDTH-1] == bb[WIDTH-1])
                 && (sum[WIDTH-1] != a[WIDTH-1]);

    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_u;
    logic             alu_s;

    always_comb begin
        alu_res = sum;
        alu_c   = 1'b0;
        alu_u   = 1'b0;
        alu_s   = 1'b0;
        case (bus.func)
            F_SLL:  alu_res = b << shamt;
            F_SRL:  alu_res = b >> shamt;
            F_SRA:  alu_res = $signed(b) >>> shamt;
            F_AND:  alu_res = a & b;
            F_OR:   alu_res = a | b;
            F_XOR:  alu_res = a ^ b;
            F_NOR:  alu_res = ~(a | b);
            F_MFHI: alu_res = hi_q;
            F_MFLO: alu_res = lo_q;
            F_ADD: begin
                alu_c = carry;
                alu_u = carry;
                alu_s = sov_c;
            end
            F_SUB: begin
                alu_c = carry;
                alu_u = ~carry;
                alu_s = sov_c;
            end
            F_SLT: begin
                alu_res = {{(WIDTH-1){1'b0}}, sov_c ^ sum[WIDTH-1]};
                alu_c   = carry;
                alu_u   = ~carry;
                alu_s   = sov_c;
            end
            default: alu_res = sum;
        endcase
    end

    logic             is_md;
    logic             md_div;
    logic             md_sgn;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;

    assign is_md  = (bus.func == F_MULT) || (bus.func == F_MULTU)
                 || (bus.func == F_DIV)  || (bus.func == F_DIVU);
    assign md_div = (bus.func == F_DIV)  || (bus.func == F_DIVU);
    assign md_sgn = (bus.func == F_MULT) || (bus.func == F_DIV);
    assign abs_a  = (md_sgn && a[WIDTH-1]) ? '0 - a : a;
    assign abs_b  = (md_sgn && b[WIDTH-1]) ? '0 - b : b;

    // One shift-add or restoring-subtract step on the {acc_hi,acc_lo} pair.
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_sh;
    logic [WIDTH:0]     div_diff;
    logic               div_ok;
    logic [2*WIDTH-1:0] prod_neg;

    assign mul_sum  = {1'b0, acc_hi}
                    + {1'b0, acc_lo[0] ? dvs : '0};
    assign div_sh   = {acc_hi, acc_lo[WIDTH-1]};
    assign div_diff = div_sh - {1'b0, dvs};
    assign div_ok   = ~div_diff[WIDTH];
    assign prod_neg = '0 - {acc_hi, acc_lo};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            res_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            zero_q  <= 1'b0;
            cout_q  <= 1'b0;
            uov_q   <= 1'b0;
            sov_q   <= 1'b0;
            dz_q    <= 1'b0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            dvs     <= '0;
            cnt     <= '0;
            is_div  <= 1'b0;
            neg_p   <= 1'b0;
            neg_r   <= 1'b0;
            dz_pend <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start && is_md) begin
                        busy_q <= 1'b1;
                        is_div <= md_div;
                        neg_p  <= md_sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_r  <= md_sgn && a[WIDTH-1];
                        cnt    <= '0;
                        if (md_div && (b == '0)) begin
                            acc_hi  <= a;
                            acc_lo  <= '1;
                            dz_pend <= 1'b1;
                            state   <= DONE;
                        end else begin
                            acc_hi  <= '0;
                            acc_lo  <= md_div ? abs_a : abs_b;
                            dvs     <= md_div ? abs_b : abs_a;
                            dz_pend <= 1'b0;
                            state   <= CALC;
                        end
                    end else if (bus.start) begin
                        res_q  <= alu_res;
                        zero_q <= (alu_res == '0);
                        cout_q <= alu_c;
                        uov_q  <= alu_u;
                        sov_q  <= alu_s;
                        dz_q   <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                CALC: begin
                    if (is_div) begin
                        acc_hi <= div_ok ? div_diff[WIDTH-1:0]
                                         : div_sh[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], div_ok};
                    end else begin
                        acc_hi <= mul_sum[WIDTH:1];
                        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == SHW'(WIDTH-1))
                        state <= FIX;
                end
                FIX: begin
                    // Truncating division: remainder follows the dividend.
                    if (is_div) begin
                        if (neg_p) acc_lo <= '0 - acc_lo;
                        if (neg_r) acc_hi <= '0 - acc_hi;
                    end else if (neg_p) begin
                        {acc_hi, acc_lo} <= prod_neg;
                    end
                    state <= DONE;
                end
                DONE: begin
                    hi_q   <= acc_hi;
                    lo_q   <= acc_lo;
                    res_q  <= acc_lo;
                    zero_q <= (acc_lo == '0);
                    cout_q <= 1'b0;
                    uov_q  <= 1'b0;
                    sov_q  <= 1'b0;
                    dz_q   <= dz_pend;
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.res  = res_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.zero = zero_q;
    assign bus.cout = cout_q;
    assign bus.uov  = uov_q;
    assign bus.sov  = sov_q;
    assign bus.dz   = dz_q;
endmodule

// File: tb/tb_ee457_alu_muldiv.sv
// Directed vector bench for ee457_alu_muldiv (32-bit and 8-bit builds).
// Latency is counted in clock edges after the launch edge.
module tb_ee457_alu_muldiv;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    ee457_alu_muldiv_if #(.WIDTH(32)) b32 ();
    ee457_alu_muldiv_if #(.WIDTH(8))  b8 ();

    ee457_alu_muldiv #(.WIDTH(32)) u32 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b32)
    );

    ee457_alu_muldiv #(.WIDTH(8)) u8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [3:0]  flg;
        logic        chk_hl;
        int          lat;
    } vec_t;

    localparam int NV = 26;
    vec_t v[NV];

    function automatic vec_t mk(
        input logic [5:0] f, input logic [31:0] a, b, res,
        input logic [3:0] flg, input logic chk_hl,
        input logic [31:0] hi, lo, input int lat);
        vec_t t;
        t.f = f; t.a = a; t.b = b; t.res = res;
        t.flg = flg; t.chk_hl = chk_hl;
        t.hi = hi; t.lo = lo; t.lat = lat;
        return t;
    endfunction

    task automatic chk(input string nm,
                       input logic [63:0] act, exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic launch(input logic [5:0] f,
                          input logic [31:0] a, b);
        @(negedge clk);
        b32.func  = f;
        b32.opa   = a;
        b32.opb   = b;
        b32.start = 1'b1;
        @(posedge clk);
        #1;
        b32.start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (b32.done !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic wait_done8(output int lat);
        lat = 0;
        while (b8.done !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic go8(input logic [5:0] f,
                       input logic [7:0] a, b, output int lat);
        @(negedge clk);
        b8.func  = f;
        b8.opa   = a;
        b8.opb   = b;
        b8.start = 1'b1;
        @(posedge clk);
        #1;
        b8.start = 1'b0;
        wait_done8(lat);
    endtask

    task automatic run_vec(input int i);
        int    lat;
        string n;
        n = $sformatf("v%0d", i);
        launch(v[i].f, v[i].a, v[i].b);
        wait_done(lat);
        chk({n, ".lat"},  64'(lat), 64'(v[i].lat));
        chk({n, ".res"},  64'(b32.res), 64'(v[i].res));
        chk({n, ".zero"}, 64'(b32.zero), 64'(v[i].res == 32'h0));
        chk({n, ".cout"}, 64'(b32.cout), 64'(v[i].flg[3]));
        chk({n, ".uov"},  64'(b32.uov), 64'(v[i].flg[2]));
        chk({n, ".sov"},  64'(b32.sov), 64'(v[i].flg[1]));
        chk({n, ".dz"},   64'(b32.dz), 64'(v[i].flg[0]));
        chk({n, ".busy"}, 64'(b32.busy), 64'h0);
        if (v[i].chk_hl) begin
            chk({n, ".hi"}, 64'(b32.hi), 64'(v[i].hi));
            chk({n, ".lo"}, 64'(b32.lo), 64'(v[i].lo));
        end
        @(posedge clk);
        #1;
        chk({n, ".done1"}, 64'(b32.done), 64'h0);
    endtask

    initial begin
        int lat;
        int pulses;
        total = 0;
        bad   = 0;
        b32.start = 1'b0; b32.func = '0; b32.opa = '0; b32.opb = '0;
        b8.start  = 1'b0; b8.func  = '0; b8.opa  = '0; b8.opb  = '0;

        //                f      a            b            res          cusd hl hi           lo           lat
        v[0]  = mk(6'h20, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b0010, 0, 0, 0, 0);
        v[1]  = mk(6'h2A, 32'h80000000, 32'h00000001, 32'h00000001, 4'b1010, 0, 0, 0, 0);
        v[2]  = mk(6'h22, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 4'b0100, 0, 0, 0, 0);
        v[3]  = mk(6'h20, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b1100, 0, 0, 0, 0);
        v[4]  = mk(6'h24, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 4'b0000, 0, 0, 0, 0);
        v[5]  = mk(6'h25, 32'h12340000, 32'h00005678, 32'h12345678, 4'b0000, 0, 0, 0, 0);
        v[6]  = mk(6'h26, 32'hFFFF0000, 32'hFF00FF00, 32'h00FFFF00, 4'b0000, 0, 0, 0, 0);
        v[7]  = mk(6'h27, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 4'b0000, 0, 0, 0, 0);
        v[8]  = mk(6'h00, 32'h00000024, 32'h0000000F, 32'h000000F0, 4'b0000, 0, 0, 0, 0);
        v[9]  = mk(6'h02, 32'h0000001F, 32'h80000000, 32'h00000001, 4'b0000, 0, 0, 0, 0);
        v[10] = mk(6'h03, 32'h00000004, 32'h80000000, 32'hF8000000, 4'b0000, 0, 0, 0, 0);
        v[11] = mk(6'h2A, 32'h00000005, 32'h00000007, 32'h00000001, 4'b0100, 0, 0, 0, 0);
        v[12] = mk(6'h22, 32'h00000007, 32'h00000007, 32'h00000000, 4'b1000, 0, 0, 0, 0);
        v[13] = mk(6'h3F, 32'h00000002, 32'h00000003, 32'h00000005, 4'b0000, 0, 0, 0, 0);
        v[14] = mk(6'h18, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFA, 4'b0000, 1,
                   32'hFFFFFFFF, 32'hFFFFFFFA, 34);
        v[15] = mk(6'h19, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFA, 4'b0000, 1,
                   32'h00000002, 32'hFFFFFFFA, 34);
        v[16] = mk(6'h1A, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 4'b0000, 1,
                   32'hFFFFFFFF, 32'hFFFFFFFD, 34);
        v[17] = mk(6'h1B, 32'h00000007, 32'h00000000, 32'hFFFFFFFF, 4'b0001, 1,
                   32'h00000007, 32'hFFFFFFFF, 1);
        v[18] = mk(6'h10, 32'h00000000, 32'h00000000, 32'h00000007, 4'b0000, 1,
                   32'h00000007, 32'hFFFFFFFF, 0);
        v[19] = mk(6'h12, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 4'b0000, 0, 0, 0, 0);
        v[20] = mk(6'h1A, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 4'b0000, 1,
                   32'h00000000, 32'h80000000, 34);
        v[21] = mk(6'h1B, 32'h00000064, 32'h00000007, 32'h0000000E, 4'b0000, 1,
                   32'h00000002, 32'h0000000E, 34);
        v[22] = mk(6'h1A, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 4'b0000, 1,
                   32'h00000001, 32'hFFFFFFFD, 34);
        v[23] = mk(6'h18, 32'h00000000, 32'h00000005, 32'h00000000, 4'b0000, 1,
                   32'h00000000, 32'h00000000, 34);
        v[24] = mk(6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 4'b0000, 1,
                   32'hFFFFFFFE, 32'h00000001, 34);
        v[25] = mk(6'h10, 32'h00000000, 32'h00000000, 32'hFFFFFFFE, 4'b0000, 0, 0, 0, 0);

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.res",  64'(b32.res), 64'h0);
        chk("rst.hi",   64'(b32.hi), 64'h0);
        chk("rst.lo",   64'(b32.lo), 64'h0);
        chk("rst.busy", 64'(b32.busy), 64'h0);
        chk("rst.done", 64'(b32.done), 64'h0);
        chk("rst.flags", 64'({b32.zero, b32.cout, b32.uov,
                              b32.sov, b32.dz}), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) run_vec(i);

        // Second start while MULT is busy must be ignored.
        launch(6'h18, 32'h00000003, 32'h00000005);
        chk("mid.busy", 64'(b32.busy), 64'h1);
        chk("mid.done0", 64'(b32.done), 64'h0);
        repeat (5) @(posedge clk);
        launch(6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(lat);
        chk("mid.lat", 64'(lat), 64'd28);
        chk("mid.hi", 64'(b32.hi), 64'h0);
        chk("mid.lo", 64'(b32.lo), 64'hF);
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (b32.done) pulses++;
        end
        chk("mid.nodone", 64'(pulses), 64'h0);

        // Asynchronous reset in the middle of a DIV.
        launch(6'h1A, 32'h00000064, 32'h00000007);
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar.res",  64'(b32.res), 64'h0);
        chk("ar.lo",   64'(b32.lo), 64'h0);
        chk("ar.busy", 64'(b32.busy), 64'h0);
        chk("ar.done", 64'(b32.done), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        launch(6'h20, 32'h00000001, 32'h00000001);
        wait_done(lat);
        chk("ar.add.lat", 64'(lat), 64'h0);
        chk("ar.add.res", 64'(b32.res), 64'h2);
        chk("ar.add.hi",  64'(b32.hi), 64'h0);
        launch(6'h1B, 32'h00000064, 32'h00000007);
        wait_done(lat);
        chk("ar.divu.lat", 64'(lat), 64'd34);
        chk("ar.divu.lo",  64'(b32.lo), 64'hE);
        chk("ar.divu.hi",  64'(b32.hi), 64'h2);

        // 8-bit build.
        go8(6'h19, 8'hFF, 8'hFF, lat);
        chk("w8.mulu.lat", 64'(lat), 64'd10);
        chk("w8.mulu.hi",  64'(b8.hi), 64'hFE);
        chk("w8.mulu.lo",  64'(b8.lo), 64'h01);
        go8(6'h03, 8'h03, 8'h80, lat);
        chk("w8.sra.lat", 64'(lat), 64'h0);
        chk("w8.sra.res", 64'(b8.res), 64'hF0);
        go8(6'h1A, 8'hF9, 8'h02, lat);
        chk("w8.div.lo", 64'(b8.lo), 64'hFD);
        chk("w8.div.hi", 64'(b8.hi), 64'hFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
